// File: rtl/tlmon_pkg.sv
// Shared lamp codes, fault-cause bit positions and monitor states for tl_conflict_monitor.
package tlmon_pkg;

  typedef logic [2:0] light_t;

  localparam light_t RED       = 3'b100;
  localparam light_t RED_AMBER = 3'b110;
  localparam light_t GREEN     = 3'b001;
  localparam light_t AMBER     = 3'b010;

  localparam logic [5:0] ALL_RED = {RED, RED};

  localparam int FLT_CODE     = 0;
  localparam int FLT_TRANS    = 1;
  localparam int FLT_CONFLICT = 2;
  localparam int FLT_WDOG     = 3;

  typedef enum logic [1:0] {
    START  = 2'd0,
    RUN    = 2'd1,
    FAULT  = 2'd2,
    RESYNC = 2'd3
  } state_t;

  function automatic logic is_legal_code(light_t c);
    return (c == RED) || (c == RED_AMBER) || (c == GREEN) || (c == AMBER);
  endfunction

endpackage

// File: rtl/tl_conflict_monitor_if.sv
// Lamp-side bundle: sequencer aspects and acknowledge in, safe lamp drive and fault status out.
interface tl_conflict_monitor_if;
  logic [2:0] lightsA;
  logic [2:0] lightsB;
  logic       clr_fault;
  logic [2:0] safe_lightsA;
  logic [2:0] safe_lightsB;
  logic       fault;
  logic [3:0] fault_code;

  modport master (
    output lightsA, lightsB, clr_fault,
    input  safe_lightsA, safe_lightsB, fault, fault_code
  );

  modport slave (
    input  lightsA, lightsB, clr_fault,
    output safe_lightsA, safe_lightsB, fault, fault_code
  );
endinterface

// File: rtl/tl_seq_checker.sv
// Combinational per-light check: code legality, legality of the step from the previous code, red detect.
module tl_seq_checker
  import tlmon_pkg::*;
(
  input  light_t cur,
  input  light_t prev,
  output logic   illegal_code,
  output logic   illegal_trans,
  output logic   is_red
);

  logic step_ok;

  always_comb begin
    step_ok = 1'b0;
    // Holding any code is a legal step; an illegal code is caught by the code check.
    if (cur == prev) begin
      step_ok = 1'b1;
    end else begin
      case (prev)
        RED:       step_ok = (cur == RED_AMBER);
        RED_AMBER: step_ok = (cur == GREEN);
        GREEN:     step_ok = (cur == AMBER);
        AMBER:     step_ok = (cur == RED);
        default:   step_ok = 1'b0;
      endcase
    end
  end

  assign illegal_code  = !is_legal_code(cur);
  assign illegal_trans = !step_ok;
  assign is_red        = (cur == RED);

endmodule

// File: rtl/tl_conflict_monitor.sv
// Safety monitor between the junction sequencer and the lamps; forces all-red and latches a fault on any violation.
// Optional stall watchdog is built when TLMON_WATCHDOG_EN is defined.
module tl_conflict_monitor
  import tlmon_pkg::*;
#(
  parameter int RESYNC_CYCLES   = 4,
  parameter int WATCHDOG_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  tl_conflict_monitor_if.slave  bus
);

  localparam int CLEAN_W = $clog2(RESYNC_CYCLES + 1);
  localparam logic [3:0] START_MASK  = (4'b1 << FLT_CODE) | (4'b1 << FLT_CONFLICT);
  localparam logic [3:0] RESYNC_MASK = (4'b1 << FLT_CODE) | (4'b1 << FLT_TRANS) | (4'b1 << FLT_CONFLICT);

  if (RESYNC_CYCLES < 1 || WATCHDOG_CYCLES < 1) begin : g_bad_params
    $error("tl_conflict_monitor: RESYNC_CYCLES and WATCHDOG_CYCLES must be >= 1");
  end

  light_t cur_light  [2];
  light_t prev_reg   [2];
  light_t safe_reg   [2];
  logic   [1:0] ill_code;
  logic   [1:0] ill_trans;
  logic   [1:0] is_red;

  state_t              state_reg;
  logic                fault_reg;
  logic [3:0]          fault_code_reg;
  logic [CLEAN_W-1:0]  clean_cnt_reg;
  logic                wdog_err;
  logic [3:0]          err_vec;
  logic [3:0]          start_err;
  logic [3:0]          resync_err;

  assign cur_light[0] = bus.lightsA;
  assign cur_light[1] = bus.lightsB;

  genvar gi;
  for (gi = 0; gi < 2; gi++) begin : g_chk
    tl_seq_checker u_chk (
      .cur           (cur_light[gi]),
      .prev          (prev_reg[gi]),
      .illegal_code  (ill_code[gi]),
      .illegal_trans (ill_trans[gi]),
      .is_red        (is_red[gi])
    );
  end

`ifdef TLMON_WATCHDOG_EN
  localparam int STALL_W = $clog2(WATCHDOG_CYCLES + 1);
  localparam logic [STALL_W-1:0] STALL_MAX = STALL_W'(WATCHDOG_CYCLES);

  logic [STALL_W-1:0] stall_cnt_reg;
  logic [STALL_W-1:0] stall_cnt_next;
  logic               same_pair;

  assign same_pair = (cur_light[0] == prev_reg[0]) && (cur_light[1] == prev_reg[1]);

  // Saturates at the trip level so a long stall keeps reporting instead of wrapping.
  always_comb begin
    stall_cnt_next = '0;
    if (same_pair) begin
      stall_cnt_next = (stall_cnt_reg == STALL_MAX) ? stall_cnt_reg : stall_cnt_reg + 1'b1;
    end
  end

  assign wdog_err = (stall_cnt_next == STALL_MAX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_reg <= '0;
    end else begin
      stall_cnt_reg <= stall_cnt_next;
    end
  end
`else
  assign wdog_err = 1'b0;
`endif

  always_comb begin
    err_vec               = '0;
    err_vec[FLT_CODE]     = |ill_code;
    err_vec[FLT_TRANS]    = |ill_trans;
    err_vec[FLT_CONFLICT] = ~|is_red;
    err_vec[FLT_WDOG]     = wdog_err;
  end

  assign start_err  = err_vec & START_MASK;
  assign resync_err = err_vec & RESYNC_MASK;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= START;
      prev_reg[0]    <= RED;
      prev_reg[1]    <= RED;
      safe_reg[0]    <= RED;
      safe_reg[1]    <= RED;
      fault_reg      <= 1'b0;
      fault_code_reg <= '0;
      clean_cnt_reg  <= '0;
    end else begin
      prev_reg[0] <= cur_light[0];
      prev_reg[1] <= cur_light[1];
      case (state_reg)
        START: begin
          if (|start_err) begin
            state_reg      <= FAULT;
            fault_reg      <= 1'b1;
            fault_code_reg <= fault_code_reg | start_err;
            safe_reg[0]    <= RED;
            safe_reg[1]    <= RED;
          end else begin
            state_reg   <= RUN;
            safe_reg[0] <= cur_light[0];
            safe_reg[1] <= cur_light[1];
          end
        end
        RUN: begin
          // clr_fault is not looked at here, so a simultaneous violation always wins.
          if (|err_vec) begin
            state_reg      <= FAULT;
            fault_reg      <= 1'b1;
            fault_code_reg <= fault_code_reg | err_vec;
            safe_reg[0]    <= RED;
            safe_reg[1]    <= RED;
          end else begin
            safe_reg[0] <= cur_light[0];
            safe_reg[1] <= cur_light[1];
          end
        end
        FAULT: begin
          safe_reg[0] <= RED;
          safe_reg[1] <= RED;
          if (bus.clr_fault) begin
            state_reg      <= RESYNC;
            fault_code_reg <= '0;
            clean_cnt_reg  <= '0;
          end
        end
        RESYNC: begin
          safe_reg[0] <= RED;
          safe_reg[1] <= RED;
          if (|resync_err) begin
            clean_cnt_reg <= '0;
          end else if (clean_cnt_reg == CLEAN_W'(RESYNC_CYCLES - 1)) begin
            state_reg     <= RUN;
            fault_reg     <= 1'b0;
            clean_cnt_reg <= '0;
            safe_reg[0]   <= cur_light[0];
            safe_reg[1]   <= cur_light[1];
          end else begin
            clean_cnt_reg <= clean_cnt_reg + 1'b1;
          end
        end
        default: begin
          state_reg   <= START;
          safe_reg[0] <= RED;
          safe_reg[1] <= RED;
        end
      endcase
    end
  end

  assign bus.safe_lightsA = safe_reg[0];
  assign bus.safe_lightsB = safe_reg[1];
  assign bus.fault        = fault_reg;
  assign bus.fault_code   = fault_code_reg;

endmodule
